fwd_hazard_scoreboard: RTL and testbench
========================================

Name: fwd_hazard_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the N-stage integer pipeline.
- Tracks in-flight register writers in an internal shift-register scoreboard fed from ID, so the datapath no longer supplies EX/MEM and MEM/WB destination fields.
- Produces registered per-source forward selects for the instruction entering EX, a combinational load-use stall for ID, and a saturating stall performance counter.
- Forwarding uses youngest-writer priority and has a configurable load-result stage.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, tracked stages after ID (slot 0 = EX, 1 = MEM, ..., DEPTH-1 = WB); minimum 2.
- LOAD_STAGE, 2, forward code from which a load result is available (2 = MEM/WB latch); legal range 1..DEPTH-1.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  source A of ID instruction.
- id_rt  in  REG_AW  source B of ID instruction.
- id_rd  in  REG_AW  destination of ID instruction.
- id_regwrite  in  1  ID instruction writes id_rd.
- id_is_load  in  1  ID instruction is a load.
- pipe_freeze  in  1  whole pipeline held (e.g. memory wait); no state advances.
- flush  in  1  kill ID instruction (branch redirect).
- stall_out  out  1  combinational load-use stall to PC/IF/ID.
- ex_fwd_a  out  clog2(DEPTH)  registered forward select, source A, for the instruction in EX.
- ex_fwd_b  out  clog2(DEPTH)  same, source B.
- stall_cnt  out  CNT_W  stall cycles since reset.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Slot content: each slot s[j] holds {valid, rd, regwrite, is_load}.
- Reset: all slot valid bits = 0; ex_fwd_a = 0, ex_fwd_b = 0, stall_cnt = 0. stall_out is then 0 because no slot matches.
- Reset mid-operation discards every in-flight entry; no forwarding from pre-reset writers.
- Match rule: s[j] matches source X when s[j].valid && s[j].regwrite && s[j].rd != 0 && s[j].rd == X, for j in 0..DEPTH-2.
- Slot DEPTH-1 (WB) is never forwarded: the regfile is write-before-read.
- Priority: the lowest matching j (youngest writer) wins. Select code = j+1. No match gives code 0 (regfile).
- Code meaning: code k = value from the pipeline latch at the end of stage k (1 = EX/MEM, 2 = MEM/WB).
- Load hazard: the winning match is a load and j+1 < LOAD_STAGE.
- stall_out = id_valid && !flush && (hazard on rs || hazard on rt). Purely combinational; independent of pipe_freeze.
- Advance: when pipe_freeze == 0 at a clk edge:
  - s[j] <= s[j-1] for j >= 1.
  - s[0] <= ID entry if id_valid && !stall_out && !flush; otherwise a bubble (valid = 0).
  - ex_fwd_a/b <= the computed codes if an entry is inserted; otherwise 0.
- Freeze: when pipe_freeze == 1, all slots, ex_fwd_a/b and stall_cnt hold.
- Simultaneous flush and stall: flush wins. Bubble inserted, stall_out = 0, no count.
- stall_cnt increments on an edge with stall_out && !pipe_freeze. It saturates at all-ones with no wrap.
- Latency: forward selects are valid one edge after ID advances, aligned with the instruction in EX. Stall resolves automatically once the load reaches slot LOAD_STAGE-1.
- Illegal parameters (DEPTH < 2, LOAD_STAGE outside 1..DEPTH-1) are rejected at elaboration.

Decomposition:
- Shared package pipe_pkg:
  - scoreboard entry struct sb_entry_t.
  - forward code constants FWD_RF = 0, FWD_EXMEM = 1, FWD_MEMWB = 2.
  - REG_AW default.
- One sub-module, fwd_src_select. It holds the combinational per-source youngest-match priority encoder and hazard flag, and is instantiated twice (rs, rt).
- The scoreboard shift register and stall counter remain in the top module.

Test Plan:
- Back-to-back ALU: add r3 issued, then sub using rs = r3 -> ex_fwd_a = 1 on the next edge, stall_out = 0.
- Two writers to r5, ages 1 and 2, consumer rt = r5 -> ex_fwd_b = 1 (youngest wins, not 2); second test with the r5 writer only at age 2 -> 2.
- lw r4 followed by an ID instruction with rs = r4 (LOAD_STAGE = 2) -> stall_out = 1 for exactly 1 cycle, bubble in slot 0, then ex_fwd_a = 2; stall_cnt = 1.
- Writer with rd = r0 and regwrite = 1, consumer rs = r0 -> code 0. Writer with regwrite = 0 to r7, consumer r7 -> code 0.
- pipe_freeze held 3 cycles during a load-use stall -> slots, ex_fwd and stall_cnt unchanged, stall_out stays 1. flush asserted with the stall -> stall_out = 0, bubble inserted.
- DEPTH = 5, LOAD_STAGE = 3, load then consumer -> 2 stall cycles, then code 3. Force stall_cnt to all-ones -> holds at all-ones. rst mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the integer pipeline forwarding/hazard logic.
package pipe_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  // Widest register address a scoreboard entry can carry.
  localparam int unsigned SB_RD_W    = 8;

  localparam int unsigned FWD_RF     = 0;
  localparam int unsigned FWD_EXMEM  = 1;
  localparam int unsigned FWD_MEMWB  = 2;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               regwrite;
    logic               is_load;
  } sb_entry_t;

endpackage

// File: rtl/fwd_src_select.sv
// Youngest-writer priority encoder and load-use hazard flag for one source operand.
module fwd_src_select
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2
) (
  input  sb_entry_t [DEPTH-2:0]         i_slots,
  input  logic [SB_RD_W-1:0]            i_src,
  output logic [$clog2(DEPTH)-1:0]      o_code_c,
  output logic                          o_hazard_c
);

  localparam int unsigned FW = $clog2(DEPTH);

  logic [FW-1:0] w_code;
  logic          w_load;

  // Scan oldest to youngest so the lowest matching slot overwrites the result.
  always_comb begin
    w_code = FW'(FWD_RF);
    w_load = 1'b0;
    for (int j = int'(DEPTH) - 2; j >= 0; j--) begin
      if (i_slots[j].valid && i_slots[j].regwrite &&
          (i_slots[j].rd != '0) && (i_slots[j].rd == i_src)) begin
        w_code = FW'(j + 1);
        w_load = i_slots[j].is_load;
      end
    end
  end

  // A load winner is only usable once it reaches the configured result stage.
  always_comb begin
    o_code_c   = w_code;
    o_hazard_c = w_load && (int'(w_code) < int'(LOAD_STAGE));
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and load-use hazard unit with an internal in-flight writer scoreboard.
module fwd_hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs,
  input  logic [REG_AW-1:0]        id_rt,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_regwrite,
  input  logic                     id_is_load,
  input  logic                     pipe_freeze,
  input  logic                     flush,
  output logic                     stall_out,
  output logic [$clog2(DEPTH)-1:0] ex_fwd_a,
  output logic [$clog2(DEPTH)-1:0] ex_fwd_b,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned FW = $clog2(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fwd_hazard_scoreboard: DEPTH must be at least 2");
  end
  if ((LOAD_STAGE < 1) || (LOAD_STAGE > DEPTH - 1)) begin : g_bad_load_stage
    $fatal(1, "fwd_hazard_scoreboard: LOAD_STAGE must lie in 1..DEPTH-1");
  end
  if (REG_AW > SB_RD_W) begin : g_bad_reg_aw
    $fatal(1, "fwd_hazard_scoreboard: REG_AW wider than scoreboard entry");
  end

  // The WB slot never forwards, so only slots EX..DEPTH-2 are kept.
  sb_entry_t [DEPTH-2:0] r_slots;
  logic [FW-1:0]         r_fwd_a;
  logic [FW-1:0]         r_fwd_b;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic [FW-1:0]         w_code_a;
  logic [FW-1:0]         w_code_b;
  logic                  w_haz_a;
  logic                  w_haz_b;
  logic                  w_stall;
  logic                  w_insert;
  sb_entry_t             w_id_entry;

  fwd_src_select #(
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE)
  ) u_sel_rs (
    .i_slots    (r_slots),
    .i_src      (SB_RD_W'(id_rs)),
    .o_code_c   (w_code_a),
    .o_hazard_c (w_haz_a)
  );

  fwd_src_select #(
    .DEPTH      (DEPTH),
    .LOAD_STAGE (LOAD_STAGE)
  ) u_sel_rt (
    .i_slots    (r_slots),
    .i_src      (SB_RD_W'(id_rt)),
    .o_code_c   (w_code_b),
    .o_hazard_c (w_haz_b)
  );

  // Stall/insert decisions for the ID instruction; flush overrides stall.
  always_comb begin
    w_stall             = id_valid && !flush && (w_haz_a || w_haz_b);
    w_insert            = id_valid && !flush && !w_stall;
    w_id_entry          = '0;
    w_id_entry.valid    = 1'b1;
    w_id_entry.rd       = SB_RD_W'(id_rd);
    w_id_entry.regwrite = id_regwrite;
    w_id_entry.is_load  = id_is_load;
  end

  // Scoreboard shift, EX forward select latch and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slots     <= '0;
      r_fwd_a     <= '0;
      r_fwd_b     <= '0;
      r_stall_cnt <= '0;
    end else if (!pipe_freeze) begin
      for (int j = int'(DEPTH) - 2; j >= 1; j--) begin
        r_slots[j] <= r_slots[j-1];
      end
      r_slots[0] <= w_insert ? w_id_entry : sb_entry_t'('0);
      r_fwd_a    <= w_insert ? w_code_a : FW'(FWD_RF);
      r_fwd_b    <= w_insert ? w_code_b : FW'(FWD_RF);
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_out = w_stall;
  assign ex_fwd_a  = r_fwd_a;
  assign ex_fwd_b  = r_fwd_b;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed scoreboard bench: default instance (DEPTH 3) and a deep instance
// (DEPTH 5, LOAD_STAGE 3, 2-bit counter to reach saturation).
module tb_fwd_hazard_scoreboard;
  import pipe_pkg::*;

  typedef struct {
    int fa;
    int fb;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters.
  logic       a_rst, a_v, a_we, a_ld, a_fz, a_fl;
  logic [4:0] a_rs, a_rt, a_rd;
  logic       a_stall;
  logic [1:0] a_fa, a_fb;
  logic [31:0] a_cnt;

  // Instance B: deep pipeline, late load result, narrow counter.
  logic       b_rst, b_v, b_we, b_ld, b_fz, b_fl;
  logic [4:0] b_rs, b_rt, b_rd;
  logic       b_stall;
  logic [2:0] b_fa, b_fb;
  logic [1:0] b_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   step     = 0;
  exp_t exp_q[$];

  fwd_hazard_scoreboard u_dut_a (
    .clk(clk), .rst(a_rst), .id_valid(a_v), .id_rs(a_rs), .id_rt(a_rt),
    .id_rd(a_rd), .id_regwrite(a_we), .id_is_load(a_ld), .pipe_freeze(a_fz),
    .flush(a_fl), .stall_out(a_stall), .ex_fwd_a(a_fa), .ex_fwd_b(a_fb),
    .stall_cnt(a_cnt)
  );

  fwd_hazard_scoreboard #(.REG_AW(5), .DEPTH(5), .LOAD_STAGE(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(b_rst), .id_valid(b_v), .id_rs(b_rs), .id_rt(b_rt),
    .id_rd(b_rd), .id_regwrite(b_we), .id_is_load(b_ld), .pipe_freeze(b_fz),
    .flush(b_fl), .stall_out(b_stall), .ex_fwd_a(b_fa), .ex_fwd_b(b_fb),
    .stall_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL step %0d %s: got %0d expected %0d", step, tag, got, exp);
    end
  endtask

  // One ID cycle: drive at negedge, check stall, queue expectations, check after the edge.
  task automatic cyc(input bit inst_b, input logic r, input logic v,
                     input int rs, input int rt, input int rd,
                     input logic we, input logic ld, input logic fz, input logic fl,
                     input logic es, input int ea, input int eb, input int ec);
    exp_t e;
    step++;
    @(negedge clk);
    if (!inst_b) begin
      a_rst = r; a_v = v; a_rs = 5'(rs); a_rt = 5'(rt); a_rd = 5'(rd);
      a_we = we; a_ld = ld; a_fz = fz; a_fl = fl;
    end else begin
      b_rst = r; b_v = v; b_rs = 5'(rs); b_rt = 5'(rt); b_rd = 5'(rd);
      b_we = we; b_ld = ld; b_fz = fz; b_fl = fl;
    end
    #1;
    check("stall_out", inst_b ? 32'(b_stall) : 32'(a_stall), 32'(es));
    exp_q.push_back('{fa: ea, fb: eb, cnt: ec});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("ex_fwd_a",  inst_b ? 32'(b_fa)  : 32'(a_fa), 32'(e.fa));
    check("ex_fwd_b",  inst_b ? 32'(b_fb)  : 32'(a_fb), 32'(e.fb));
    check("stall_cnt", inst_b ? 32'(b_cnt) : a_cnt,     32'(e.cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; a_v = 1'b0; a_rs = '0; a_rt = '0; a_rd = '0;
    a_we = 1'b0; a_ld = 1'b0; a_fz = 1'b0; a_fl = 1'b0;
    b_rst = 1'b1; b_v = 1'b0; b_rs = '0; b_rt = '0; b_rd = '0;
    b_we = 1'b0; b_ld = 1'b0; b_fz = 1'b0; b_fl = 1'b0;
    repeat (2) @(posedge clk);

    //    B  rst v  rs  rt  rd we ld fz fl stall fa  fb  cnt
    // Reset state
    cyc(0, 1, 0,  0,  0,  0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, 0);
    // Back-to-back ALU: add r3, then sub rs=r3
    cyc(0, 0, 1,  1,  2,  3, 1, 0, 0, 0, 0, FWD_RF,    FWD_RF, 0);
    cyc(0, 0, 1,  3,  6,  8, 1, 0, 0, 0, 0, FWD_EXMEM, FWD_RF, 0);
    // Two writers to r5: youngest wins, then only the older one remains forwardable
    cyc(0, 0, 1,  0,  0,  5, 1, 0, 0, 0, 0, FWD_RF, FWD_RF,    0);
    cyc(0, 0, 1,  0,  0,  5, 1, 0, 0, 0, 0, FWD_RF, FWD_RF,    0);
    cyc(0, 0, 1,  3,  5,  0, 0, 0, 0, 0, 0, FWD_RF, FWD_EXMEM, 0);
    cyc(0, 0, 1,  1,  5, 10, 0, 0, 0, 0, 0, FWD_RF, FWD_MEMWB, 0);
    // r0 writer and regwrite=0 writer never forward
    cyc(0, 0, 1,  0,  0,  0, 1, 0, 0, 0, 0, FWD_RF, FWD_RF, 0);
    cyc(0, 0, 1,  0,  0,  7, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, 0);
    cyc(0, 0, 1,  7,  7,  0, 0, 0, 0, 0, 0, FWD_RF, FWD_RF, 0);
    // Load-use: lw r4, consumer rs=r4 stalls once then gets MEM/WB
    cyc(0, 0, 1,  1,  0,  4, 1, 1, 0, 0, 0, FWD_RF,    FWD_RF, 0);
    cyc(0, 0, 1,  4,  2, 11, 1, 0, 0, 0, 1, FWD_RF,    FWD_RF, 1);
    cyc(0, 0, 1,  4,  2, 11, 1, 0, 0, 0, 0, FWD_MEMWB, FWD_RF, 1);
    // lw r12 (rs=r11 forwards from EX/MEM), consumer frozen for 3 cycles mid-stall
    cyc(0, 0, 1, 11,  0, 12, 1, 1, 0, 0, 0, FWD_EXMEM, FWD_RF, 1);
    cyc(0, 0, 1, 12, 12, 13, 1, 0, 1, 0, 1, FWD_EXMEM, FWD_RF, 1);
    cyc(0, 0, 1, 12, 12, 13, 1, 0, 1, 0, 1, FWD_EXMEM, FWD_RF, 1);
    cyc(0, 0, 1, 12, 12, 13, 1, 0, 1, 0, 1, FWD_EXMEM, FWD_RF, 1);
    cyc(0, 0, 1, 12, 12, 13, 1, 0, 0, 0, 1, FWD_RF,    FWD_RF, 2);
    cyc(0, 0, 1, 12, 12, 13, 1, 0, 0, 0, 0, FWD_MEMWB, FWD_MEMWB, 2);
    // Flush together with a load-use hazard: no stall, bubble, no count
    cyc(0, 0, 1,  0,  0, 14, 1, 1, 0, 0, 0, FWD_RF,    FWD_RF, 2);
    cyc(0, 0, 1, 14,  0, 15, 1, 0, 0, 1, 0, FWD_RF,    FWD_RF, 2);
    cyc(0, 0, 1, 14,  0, 21, 1, 0, 0, 0, 0, FWD_MEMWB, FWD_RF, 2);
    // Reset mid-stream discards in-flight writers
    cyc(0, 0, 1, 21,  0, 20, 1, 0, 0, 0, 0, FWD_EXMEM, FWD_RF, 2);
    cyc(0, 1, 1, 20,  0,  0, 0, 0, 0, 0, 0, FWD_RF,    FWD_RF, 0);
    cyc(0, 0, 1, 20, 20,  0, 0, 0, 0, 0, 0, FWD_RF,    FWD_RF, 0);

    // Deep instance: two stall cycles per load-use, code 3 then 4, WB not forwarded
    cyc(1, 1, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1,  0,  0,  4, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1,  4,  0,  9, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(1, 0, 1,  4,  0,  9, 0, 0, 0, 0, 1, 0, 0, 2);
    cyc(1, 0, 1,  4,  0,  9, 0, 0, 0, 0, 0, 3, 0, 2);
    cyc(1, 0, 1,  0,  0,  6, 1, 1, 0, 0, 0, 0, 0, 2);
    cyc(1, 0, 1,  0,  6,  9, 0, 0, 0, 0, 1, 0, 0, 3);
    // Counter saturated at all-ones: another stall cycle does not wrap
    cyc(1, 0, 1,  0,  6,  9, 0, 0, 0, 0, 1, 0, 0, 3);
    cyc(1, 0, 1,  0,  6,  9, 0, 0, 0, 0, 0, 0, 3, 3);
    cyc(1, 0, 1,  0,  6,  9, 0, 0, 0, 0, 0, 0, 4, 3);
    cyc(1, 0, 1,  0,  6,  9, 0, 0, 0, 0, 0, 0, 0, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
